// File: rtl/rf_wport_arbiter.sv
// Purpose : shares the regfile write port between WB (always wins) and LU results
//           queued in a small FIFO; a busy-bit scoreboard flags registers with
//           LU writes outstanding.
// Latency : port mux is combinational; a queued LU result can reach the port the
//           cycle after it is pushed, provided WB leaves the port idle.
// Backpr. : lu_ready drops when the FIFO is full (from registered count only);
//           WB is never stalled.
// Ports   : clk/rst (async, active-low); wb_we/wb_wa/wb_wd WB request;
//           lu_valid/lu_wa/lu_wd/lu_ready LU result handshake; iss_valid/iss_wa
//           LU issue (scoreboard set); q_ra1/q_ra2 -> busy1/busy2 hazard query;
//           rf_we3/rf_wa3/rf_wd3 to regfile; fifo_cnt occupancy; sb_err sticky
//           double-issue flag.
module rf_wport_arbiter #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wb_we,
   input  logic [AW-1:0] wb_wa,
   input  logic [DW-1:0] wb_wd,
   input  logic          lu_valid,
   input  logic [AW-1:0] lu_wa,
   input  logic [DW-1:0] lu_wd,
   output logic          lu_ready,
   input  logic          iss_valid,
   input  logic [AW-1:0] iss_wa,
   input  logic [AW-1:0] q_ra1,
   input  logic [AW-1:0] q_ra2,
   output logic          busy1,
   output logic          busy2,
   output logic          rf_we3,
   output logic [AW-1:0] rf_wa3,
   output logic [DW-1:0] rf_wd3,
   output logic [AW-1:0] fifo_cnt,
   output logic          sb_err
);

   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NREG = 1 << AW;
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

   // FIFO storage (not reset: only entries between the pointers are ever read)
   logic [AW-1:0] fa [DEPTH];
   logic [DW-1:0] fd [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   cnt;

   logic [NREG-1:0] busy, busy_nxt;

   logic          wb_req;
   logic          fifo_empty;
   logic          push, pop;
   logic          iss_set;
   logic [AW-1:0] head_wa;
   logic [DW-1:0] head_wd;

   assign head_wa    = fa[rd_ptr];
   assign head_wd    = fd[rd_ptr];
   assign fifo_empty = (cnt == '0);

   // A WB write to r0 is not a real request, so the FIFO may use the slot.
   assign wb_req   = wb_we && (wb_wa != '0);

   // Readiness comes from the registered count only; a full FIFO never
   // accepts even if it pops this cycle, keeping lu_ready free of WB timing.
   assign lu_ready = rst && (cnt != CNT_FULL);
   assign push     = lu_valid && lu_ready;
   assign pop      = rst && !wb_req && !fifo_empty;
   assign iss_set  = iss_valid && (iss_wa != '0);

   assign fifo_cnt = AW'(cnt);

   // Write-port mux. Entries addressed to r0 still pop but produce no write.
   always_comb begin
      rf_we3 = 1'b0;
      rf_wa3 = '0;
      rf_wd3 = '0;
      if (rst) begin
         if (wb_req) begin
            rf_we3 = 1'b1;
            rf_wa3 = wb_wa;
            rf_wd3 = wb_wd;
         end else if (pop && (head_wa != '0)) begin
            rf_we3 = 1'b1;
            rf_wa3 = head_wa;
            rf_wd3 = head_wd;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fa[wr_ptr] <= lu_wa;
         fd[wr_ptr] <= lu_wd;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      cnt <= cnt + 1'b1;
         else if (pop && !push) cnt <= cnt - 1'b1;
      end
   end

   // Scoreboard: clear on retire, then set on issue so a same-cycle set wins.
   always_comb begin
      busy_nxt = busy;
      if (pop)     busy_nxt[head_wa] = 1'b0;
      if (iss_set) busy_nxt[iss_wa]  = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy   <= '0;
         sb_err <= 1'b0;
      end else begin
         busy <= busy_nxt;
         if (iss_set && busy[iss_wa]) sb_err <= 1'b1;
      end
   end

   // busy[0] is held at 0, so a query of r0 reads as not busy.
   assign busy1 = busy[q_ra1];
   assign busy2 = busy[q_ra2];

endmodule

// File: tb/tb_rf_wport_arbiter.sv
module tb_rf_wport_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk;
   logic          rst;
   logic          wb_we;
   logic [AW-1:0] wb_wa;
   logic [DW-1:0] wb_wd;
   logic          lu_valid;
   logic [AW-1:0] lu_wa;
   logic [DW-1:0] lu_wd;
   logic          lu_ready;
   logic          iss_valid;
   logic [AW-1:0] iss_wa;
   logic [AW-1:0] q_ra1;
   logic [AW-1:0] q_ra2;
   logic          busy1;
   logic          busy2;
   logic          rf_we3;
   logic [AW-1:0] rf_wa3;
   logic [DW-1:0] rf_wd3;
   logic [AW-1:0] fifo_cnt;
   logic          sb_err;

   int n_chk  = 0;
   int n_pass = 0;

   rf_wport_arbiter #(.DW(DW), .AW(AW), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
      .lu_valid(lu_valid), .lu_wa(lu_wa), .lu_wd(lu_wd), .lu_ready(lu_ready),
      .iss_valid(iss_valid), .iss_wa(iss_wa),
      .q_ra1(q_ra1), .q_ra2(q_ra2), .busy1(busy1), .busy2(busy2),
      .rf_we3(rf_we3), .rf_wa3(rf_wa3), .rf_wd3(rf_wd3),
      .fifo_cnt(fifo_cnt), .sb_err(sb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Inputs change 1 time unit after posedge; checks follow 1 unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
      lu_valid = 1'b1; lu_wa = 5'd5; lu_wd = 32'h1234;
      iss_valid = 1'b1; iss_wa = 5'd5;
      q_ra1 = 5'd5; q_ra2 = 5'd0;

      // 1. reset with live requests
      step(); step();
      #1;
      chk("rst_lu_ready", 32'(lu_ready), 32'd0);
      chk("rst_we3",      32'(rf_we3),   32'd0);
      chk("rst_cnt",      32'(fifo_cnt), 32'd0);
      chk("rst_busy1",    32'(busy1),    32'd0);
      chk("rst_busy2",    32'(busy2),    32'd0);
      chk("rst_sb_err",   32'(sb_err),   32'd0);
      step();
      lu_valid = 1'b0; iss_valid = 1'b0;
      rst = 1'b1;

      // 2. idle drain
      step();
      iss_valid = 1'b1; iss_wa = 5'd5;
      step();
      iss_valid = 1'b0;
      lu_valid = 1'b1; lu_wa = 5'd5; lu_wd = 32'hDEADBEEF;
      #1;
      chk("t2_busy_set",  32'(busy1),    32'd1);
      chk("t2_ready",     32'(lu_ready), 32'd1);
      chk("t2_we3_empty", 32'(rf_we3),   32'd0);
      step();
      lu_valid = 1'b0;
      #1;
      chk("t2_cnt",  32'(fifo_cnt), 32'd1);
      chk("t2_we3",  32'(rf_we3),   32'd1);
      chk("t2_wa3",  32'(rf_wa3),   32'd5);
      chk("t2_wd3",  rf_wd3,        32'hDEADBEEF);
      chk("t2_busy_before", 32'(busy1), 32'd1);
      step();
      #1;
      chk("t2_busy_clr", 32'(busy1),    32'd0);
      chk("t2_cnt0",     32'(fifo_cnt), 32'd0);
      chk("t2_we3_idle", 32'(rf_we3),   32'd0);

      // 3. WB priority
      lu_valid = 1'b1; lu_wa = 5'd7; lu_wd = 32'h11;
      step();
      lu_valid = 1'b0;
      wb_we = 1'b1; wb_wa = 5'd3; wb_wd = 32'h22;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("t3_wb_wa3", 32'(rf_wa3),   32'd3);
         chk("t3_wb_wd3", rf_wd3,        32'h22);
         chk("t3_cnt",    32'(fifo_cnt), 32'd1);
         step();
      end
      wb_we = 1'b0;
      #1;
      chk("t3_lu_we3", 32'(rf_we3), 32'd1);
      chk("t3_lu_wa3", 32'(rf_wa3), 32'd7);
      chk("t3_lu_wd3", rf_wd3,      32'h11);
      step();
      #1;
      chk("t3_cnt0", 32'(fifo_cnt), 32'd0);

      // 4. full / ordering / pointer wrap
      for (int r = 0; r < 3; r++) begin
         wb_we = 1'b1; wb_wa = 5'd1; wb_wd = 32'h0;
         for (int i = 0; i < 3; i++) begin
            lu_valid = 1'b1;
            lu_wa = 5'(10 + i);
            lu_wd = 32'(32'hA000 + r*16 + i);
            #1;
            if (i < 2) chk("t4_ready", 32'(lu_ready), 32'd1);
            else begin
               chk("t4_full_ready", 32'(lu_ready), 32'd0);
               chk("t4_full_cnt",   32'(fifo_cnt), 32'd2);
            end
            step();
         end
         wb_we = 1'b0;
         #1;
         chk("t4_pop1_wa", 32'(rf_wa3), 32'd10);
         chk("t4_pop1_wd", rf_wd3, 32'(32'hA000 + r*16));
         chk("t4_ready_full", 32'(lu_ready), 32'd0);
         step();
         chk("t4_pop2_wa", 32'(rf_wa3), 32'd11);
         chk("t4_pop2_wd", rf_wd3, 32'(32'hA000 + r*16 + 1));
         step();
         lu_valid = 1'b0;
         #1;
         chk("t4_cnt_pp",  32'(fifo_cnt), 32'd1);
         chk("t4_pop3_wa", 32'(rf_wa3), 32'd12);
         chk("t4_pop3_wd", rf_wd3, 32'(32'hA000 + r*16 + 2));
         step();
         chk("t4_cnt0", 32'(fifo_cnt), 32'd0);
      end

      // 5. simultaneous set and clear of r9
      iss_valid = 1'b1; iss_wa = 5'd9; q_ra1 = 5'd9;
      step();
      iss_valid = 1'b0;
      lu_valid = 1'b1; lu_wa = 5'd9; lu_wd = 32'h99;
      #1;
      chk("t5_busy", 32'(busy1), 32'd1);
      step();
      lu_valid = 1'b0;
      iss_valid = 1'b1; iss_wa = 5'd9;
      #1;
      chk("t5_wa3",      32'(rf_wa3), 32'd9);
      chk("t5_wd3",      rf_wd3,      32'h99);
      chk("t5_err_pre",  32'(sb_err), 32'd0);
      step();
      iss_valid = 1'b0;
      #1;
      chk("t5_busy_kept", 32'(busy1),    32'd1);
      chk("t5_sb_err",    32'(sb_err),   32'd1);
      chk("t5_cnt0",      32'(fifo_cnt), 32'd0);

      // 6. zero register
      lu_valid = 1'b1; lu_wa = 5'd0; lu_wd = 32'h55;
      wb_we = 1'b1; wb_wa = 5'd0; wb_wd = 32'h66;
      q_ra2 = 5'd0;
      #1;
      chk("t6_we3_wb0", 32'(rf_we3), 32'd0);
      step();
      lu_valid = 1'b0;
      #1;
      chk("t6_cnt1",  32'(fifo_cnt), 32'd1);
      chk("t6_we3",   32'(rf_we3),   32'd0);
      chk("t6_busy2", 32'(busy2),    32'd0);
      step();
      #1;
      chk("t6_cnt0",   32'(fifo_cnt), 32'd0);
      chk("t6_sticky", 32'(sb_err),   32'd1);

      // 7. asynchronous reset discards an entry in flight
      wb_we = 1'b1; wb_wa = 5'd2; wb_wd = 32'h0;
      lu_valid = 1'b1; lu_wa = 5'd4; lu_wd = 32'h44;
      step();
      lu_valid = 1'b0;
      #1;
      chk("t7_cnt1", 32'(fifo_cnt), 32'd1);
      rst = 1'b0;
      #1;
      chk("t7_cnt_rst",  32'(fifo_cnt), 32'd0);
      chk("t7_we3_rst",  32'(rf_we3),   32'd0);
      chk("t7_err_rst",  32'(sb_err),   32'd0);
      chk("t7_busy_rst", 32'(busy1),    32'd0);
      step();
      wb_we = 1'b0;
      rst = 1'b1;
      #1;
      chk("t7_no_write", 32'(rf_we3),   32'd0);
      chk("t7_cnt_post", 32'(fifo_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
